// File: rtl/ex_pkg.sv
// Shared opcode encodings, flag bit positions and control state type for the execute unit.
package ex_pkg;

  // alu_class = 1
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;

  // alu_class = 0
  localparam logic [2:0] OP_MOV  = 3'b000;
  localparam logic [2:0] OP_MOVT = 3'b001;
  localparam logic [2:0] OP_CLR  = 3'b010;
  localparam logic [2:0] OP_SET  = 3'b011;
  localparam logic [2:0] OP_LSL  = 3'b100;
  localparam logic [2:0] OP_LSR  = 3'b101;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } ex_state_e;

endpackage

// File: rtl/ex_shifter.sv
// Iterative one-bit-per-cycle shifter; o_done marks the cycle whose step produces the final value.
module ex_shifter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SH_W   = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_right,
  input  logic [DATA_W-1:0] i_data,
  input  logic [SH_W-1:0]   i_amt,
  output logic              o_done,
  output logic [DATA_W-1:0] o_result,
  output logic              o_cout
);

  logic [DATA_W-1:0] r_data;
  logic [SH_W-1:0]   r_cnt;
  logic              r_right;
  logic [DATA_W-1:0] w_step;
  logic              w_cout;

  always_comb begin
    w_step = r_data;
    w_cout = 1'b0;
    if (r_right) begin
      w_step = {1'b0, r_data[DATA_W-1:1]};
      w_cout = r_data[0];
    end else begin
      w_step = {r_data[DATA_W-2:0], 1'b0};
      w_cout = r_data[DATA_W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_cnt   <= '0;
      r_right <= 1'b0;
    end else if (i_start) begin
      r_data  <= i_data;
      r_cnt   <= i_amt;
      r_right <= i_right;
    end else if (r_cnt != '0) begin
      r_data <= w_step;
      r_cnt  <= r_cnt - SH_W'(1);
    end
  end

  // Result and carry are taken from the step in flight so the caller can register them on this edge.
  assign o_done   = (r_cnt == SH_W'(1));
  assign o_result = w_step;
  assign o_cout   = w_cout;

endmodule

// File: rtl/ex_unit.sv
// Single-issue execute unit: one-cycle ALU/move/flag ops, iterative shifts, registered result with
// valid/ready back-pressure and architectural NZCV flags.
module ex_unit
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned SH_W   = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              alu_class,
  input  logic              use_imm,
  input  logic [2:0]        op,
  input  logic [REG_AW-1:0] dest_reg,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [DATA_W-1:0] imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [REG_AW-1:0] out_dest,
  output logic              out_wr_en,
  output logic [3:0]        flags,
  output logic              busy
);

  localparam int unsigned MSB  = DATA_W - 1;
  localparam int unsigned HALF = DATA_W / 2;

  ex_state_e         r_state, w_state_next;
  logic              r_valid;
  logic              r_wr_en;
  logic [DATA_W-1:0] r_result;
  logic [REG_AW-1:0] r_dest;
  logic [REG_AW-1:0] r_sh_dest;
  logic [3:0]        r_flags;

  logic              w_fire;
  logic [DATA_W-1:0] w_b;
  logic [SH_W-1:0]   w_amt;
  logic              w_is_shift;
  logic              w_start;
  logic              w_sh_done;
  logic              w_sh_last;
  logic [DATA_W-1:0] w_sh_result;
  logic              w_sh_cout;
  logic [3:0]        w_sh_flags;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_iss_result;
  logic [3:0]        w_iss_flags;
  logic              w_iss_wr_en;
  logic              w_iss_nz;

  assign in_ready   = (r_state == StIdle) && (!r_valid || out_ready);
  assign w_fire     = in_valid && in_ready;
  assign w_b        = use_imm ? imm : op2;
  assign w_amt      = w_b[SH_W-1:0];
  assign w_is_shift = !alu_class && ((op == OP_LSL) || (op == OP_LSR));
  assign w_start    = w_fire && w_is_shift && (w_amt != '0);
  assign w_sh_last  = (r_state == StShift) && w_sh_done;

  ex_shifter #(
    .DATA_W (DATA_W),
    .SH_W   (SH_W)
  ) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_start),
    .i_right  (op == OP_LSR),
    .i_data   (op1),
    .i_amt    (w_amt),
    .o_done   (w_sh_done),
    .o_result (w_sh_result),
    .o_cout   (w_sh_cout)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_start) w_state_next = StShift;
      StShift: if (w_sh_done) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // Result of any op that completes at issue; a shift by 0 passes op1 through with C kept.
  always_comb begin
    w_sum        = '0;
    w_iss_result = '0;
    w_iss_flags  = r_flags;
    w_iss_wr_en  = 1'b0;
    w_iss_nz     = 1'b0;
    if (alu_class) begin
      case (op)
        OP_ADD: begin
          w_sum                = {1'b0, op1} + {1'b0, w_b};
          w_iss_result         = w_sum[MSB:0];
          w_iss_flags[FLAG_C]  = w_sum[DATA_W];
          w_iss_flags[FLAG_V]  = (op1[MSB] == w_b[MSB]) && (w_sum[MSB] != op1[MSB]);
          w_iss_nz             = 1'b1;
        end
        OP_SUB: begin
          w_sum                = {1'b0, op1} - {1'b0, w_b};
          w_iss_result         = w_sum[MSB:0];
          w_iss_flags[FLAG_C]  = ~w_sum[DATA_W];
          w_iss_flags[FLAG_V]  = (op1[MSB] != w_b[MSB]) && (w_sum[MSB] != op1[MSB]);
          w_iss_nz             = 1'b1;
        end
        OP_AND: begin w_iss_result = op1 & w_b; w_iss_nz = 1'b1; end
        OP_OR:  begin w_iss_result = op1 | w_b; w_iss_nz = 1'b1; end
        OP_XOR: begin w_iss_result = op1 ^ w_b; w_iss_nz = 1'b1; end
        OP_NOT: begin w_iss_result = ~op1;      w_iss_nz = 1'b1; end
        default: ;
      endcase
    end else begin
      case (op)
        OP_MOV:         begin w_iss_result = w_b; w_iss_nz = 1'b1; end
        OP_MOVT:        begin w_iss_result = {imm[HALF-1:0], op1[HALF-1:0]}; w_iss_nz = 1'b1; end
        OP_LSL, OP_LSR: begin w_iss_result = op1; w_iss_nz = 1'b1; end
        OP_CLR:         w_iss_flags = r_flags & ~imm[3:0];
        OP_SET:         w_iss_flags = r_flags | imm[3:0];
        default: ;
      endcase
    end
    if (w_iss_nz) begin
      w_iss_wr_en         = 1'b1;
      w_iss_flags[FLAG_N] = w_iss_result[MSB];
      w_iss_flags[FLAG_Z] = (w_iss_result == '0);
    end
  end

  always_comb begin
    w_sh_flags         = r_flags;
    w_sh_flags[FLAG_N] = w_sh_result[MSB];
    w_sh_flags[FLAG_Z] = (w_sh_result == '0);
    w_sh_flags[FLAG_C] = w_sh_cout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_result  <= '0;
      r_dest    <= '0;
      r_sh_dest <= '0;
      r_flags   <= '0;
    end else begin
      if (w_fire && !w_start) begin
        r_valid  <= 1'b1;
        r_wr_en  <= w_iss_wr_en;
        r_result <= w_iss_result;
        r_dest   <= dest_reg;
        r_flags  <= w_iss_flags;
      end else if (w_sh_last) begin
        r_valid  <= 1'b1;
        r_wr_en  <= 1'b1;
        r_result <= w_sh_result;
        r_dest   <= r_sh_dest;
        r_flags  <= w_sh_flags;
      end else if (out_ready) begin
        r_valid <= 1'b0;
        r_wr_en <= 1'b0;
      end
      if (w_start) r_sh_dest <= dest_reg;
    end
  end

  assign out_valid = r_valid;
  assign out_wr_en = r_wr_en;
  assign result    = r_result;
  assign out_dest  = r_dest;
  assign flags     = r_flags;
  assign busy      = (r_state == StShift);

endmodule

// File: tb/tb_ex_unit.sv
// Bench for ex_unit: directed vector table, back-pressure and reset corner cases, a 32-bit instance,
// and random ops checked against an arithmetic reference model.
module tb_ex_unit;

  localparam int FN = 3;
  localparam int FZ = 2;
  localparam int FC = 1;
  localparam int FV = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_wr_en, busy;
  logic        d_ac, d_ui;
  logic [2:0]  d_op, d_dst, out_dest;
  logic [15:0] d_a, d_b, d_im, result;
  logic [3:0]  flags;

  logic        v32_in, r32_in, v32_out, wr32, busy32;
  logic        d32_ac;
  logic [2:0]  d32_op, dest32;
  logic [31:0] d32_a, d32_im, res32;
  logic [3:0]  flags32;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] m_flags;

  typedef struct {
    logic ac; logic ui; logic [2:0] op; logic [15:0] a; logic [15:0] b; logic [15:0] im;
    logic [15:0] res; logic wr; logic [3:0] fl; int lat;
  } vec_t;

  typedef struct {
    logic [15:0] res; logic wr; logic [3:0] fl; int lat;
  } mres_t;

  vec_t tbl[18];

  always #5 clk = ~clk;

  ex_unit u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .alu_class(d_ac),
    .use_imm(d_ui), .op(d_op), .dest_reg(d_dst), .op1(d_a), .op2(d_b), .imm(d_im),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_dest(out_dest),
    .out_wr_en(out_wr_en), .flags(flags), .busy(busy)
  );

  ex_unit #(.DATA_W(32), .REG_AW(3)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32_in), .in_ready(r32_in), .alu_class(d32_ac),
    .use_imm(1'b1), .op(d32_op), .dest_reg(3'd6), .op1(d32_a), .op2(32'h0), .imm(d32_im),
    .out_valid(v32_out), .out_ready(1'b1), .result(res32), .out_dest(dest32),
    .out_wr_en(wr32), .flags(flags32), .busy(busy32)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic mres_t ref_op(input logic ac, input logic ui, input logic [2:0] o,
                                   input logic [15:0] a, input logic [15:0] op2v,
                                   input logic [15:0] im, input logic [3:0] fl);
    mres_t r;
    int unsigned ua, ub, s;
    int sa, sb, sr;
    bit nz;
    ua = 32'(a);
    ub = ui ? 32'(im) : 32'(op2v);
    sa = (ua >= 32768) ? int'(ua) - 65536 : int'(ua);
    sb = (ub >= 32768) ? int'(ub) - 65536 : int'(ub);
    s  = ub % 16;
    r.res = '0; r.wr = 1'b0; r.fl = fl; r.lat = 1; nz = 1'b0;
    if (ac) begin
      case (o)
        3'd1: begin
          r.res = 16'((ua + ub) % 65536); r.fl[FC] = (ua + ub) >= 65536;
          sr = sa + sb; r.fl[FV] = (sr > 32767) || (sr < -32768); nz = 1'b1;
        end
        3'd2: begin
          r.res = 16'((ua + 65536 - ub) % 65536); r.fl[FC] = (ua >= ub);
          sr = sa - sb; r.fl[FV] = (sr > 32767) || (sr < -32768); nz = 1'b1;
        end
        3'd3: begin r.res = 16'(ua & ub); nz = 1'b1; end
        3'd4: begin r.res = 16'(ua | ub); nz = 1'b1; end
        3'd5: begin r.res = 16'(ua ^ ub); nz = 1'b1; end
        3'd6: begin r.res = 16'(65535 - ua); nz = 1'b1; end
        default: ;
      endcase
    end else begin
      case (o)
        3'd0: begin r.res = 16'(ub); nz = 1'b1; end
        3'd1: begin r.res = 16'((32'(im) % 256) * 256 + ua % 256); nz = 1'b1; end
        3'd4: begin
          r.res = 16'((ua << s) % 65536); r.lat = int'(s) + 1; nz = 1'b1;
          if (s > 0) r.fl[FC] = ((ua >> (16 - s)) % 2) == 1;
        end
        3'd5: begin
          r.res = 16'(ua >> s); r.lat = int'(s) + 1; nz = 1'b1;
          if (s > 0) r.fl[FC] = ((ua >> (s - 1)) % 2) == 1;
        end
        3'd2: r.fl = fl & ~im[3:0];
        3'd3: r.fl = fl | im[3:0];
        default: ;
      endcase
    end
    if (nz) begin
      r.wr = 1'b1;
      r.fl[FN] = (r.res >= 16'h8000);
      r.fl[FZ] = (r.res == 16'h0);
    end
    return r;
  endfunction

  task automatic drive(input logic ac, input logic ui, input logic [2:0] o, input logic [2:0] dst,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] im);
    d_ac = ac; d_ui = ui; d_op = o; d_dst = dst; d_a = a; d_b = b; d_im = im;
  endtask

  // Issue one op with out_ready high and follow it to its result.
  task automatic run_op(input string name, input logic ac, input logic ui, input logic [2:0] o,
                        input logic [2:0] dst, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] im, input logic [15:0] e_res, input logic e_wr,
                        input logic [3:0] e_fl, input int e_lat);
    int  lat;
    bit  got;
    @(negedge clk);
    drive(ac, ui, o, dst, a, b, im);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk({name, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (out_valid) got = 1'b1;
      else begin
        chk({name, " busy"}, 32'(busy), 32'd1);
        chk({name, " in_ready_busy"}, 32'(in_ready), 32'd0);
      end
    end
    chk({name, " latency"}, 32'(lat), 32'(e_lat));
    chk({name, " result"}, 32'(result), 32'(e_res));
    chk({name, " wr_en"}, 32'(out_wr_en), 32'(e_wr));
    chk({name, " flags"}, 32'(flags), 32'(e_fl));
    chk({name, " dest"}, 32'(out_dest), 32'(dst));
    chk({name, " busy_done"}, 32'(busy), 32'd0);
  endtask

  task automatic issue32(input string name, input logic ac, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] im, input logic [31:0] e_res,
                         input logic e_wr, input logic [3:0] e_fl);
    @(negedge clk);
    d32_ac = ac; d32_op = o; d32_a = a; d32_im = im; v32_in = 1'b1;
    chk({name, " in_ready"}, 32'(r32_in), 32'd1);
    @(posedge clk);
    #1 v32_in = 1'b0;
    @(negedge clk);
    chk({name, " valid"}, 32'(v32_out), 32'd1);
    chk({name, " result"}, res32, e_res);
    chk({name, " wr_en"}, 32'(wr32), 32'(e_wr));
    chk({name, " flags"}, 32'(flags32), 32'(e_fl));
    chk({name, " dest"}, 32'(dest32), 32'd6);
    chk({name, " busy"}, 32'(busy32), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    mres_t ra, rb, rc, r;
    bit seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
    v32_in = 1'b0; d32_ac = 1'b0; d32_op = 3'd0; d32_a = '0; d32_im = '0;
    m_flags = 4'h0;

    tbl[0]  = '{1'b1, 1'b1, 3'd1, 16'h7FFF, 16'hDEAD, 16'h0001, 16'h8000, 1'b1, 4'b1001, 1};
    tbl[1]  = '{1'b1, 1'b0, 3'd2, 16'h0005, 16'h0005, 16'hFFFF, 16'h0000, 1'b1, 4'b0110, 1};
    tbl[2]  = '{1'b0, 1'b1, 3'd4, 16'h8001, 16'h0000, 16'h0003, 16'h0008, 1'b1, 4'b0000, 4};
    tbl[3]  = '{1'b1, 1'b0, 3'd3, 16'hF0F0, 16'hFF00, 16'h0000, 16'hF000, 1'b1, 4'b1000, 1};
    tbl[4]  = '{1'b1, 1'b0, 3'd1, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 4'b0110, 1};
    tbl[5]  = '{1'b1, 1'b1, 3'd6, 16'h0F0F, 16'h0000, 16'h1234, 16'hF0F0, 1'b1, 4'b1010, 1};
    tbl[6]  = '{1'b0, 1'b1, 3'd5, 16'h0003, 16'h0000, 16'h0001, 16'h0001, 1'b1, 4'b0010, 2};
    tbl[7]  = '{1'b0, 1'b0, 3'd4, 16'h1234, 16'h0010, 16'h0000, 16'h1234, 1'b1, 4'b0010, 1};
    tbl[8]  = '{1'b1, 1'b1, 3'd2, 16'h8000, 16'h0000, 16'h0001, 16'h7FFF, 1'b1, 4'b0011, 1};
    tbl[9]  = '{1'b0, 1'b1, 3'd3, 16'hFFFF, 16'h0000, 16'h0004, 16'h0000, 1'b0, 4'b0111, 1};
    tbl[10] = '{1'b1, 1'b0, 3'd7, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1'b0, 4'b0111, 1};
    tbl[11] = '{1'b0, 1'b0, 3'd2, 16'h0000, 16'h0000, 16'h0003, 16'h0000, 1'b0, 4'b0100, 1};
    tbl[12] = '{1'b0, 1'b1, 3'd0, 16'h1111, 16'h2222, 16'h8001, 16'h8001, 1'b1, 4'b1000, 1};
    tbl[13] = '{1'b0, 1'b0, 3'd1, 16'h00CD, 16'hFFFF, 16'h0012, 16'h12CD, 1'b1, 4'b0000, 1};
    tbl[14] = '{1'b1, 1'b1, 3'd4, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 4'b0100, 1};
    tbl[15] = '{1'b1, 1'b0, 3'd5, 16'hAAAA, 16'hFFFF, 16'h0000, 16'h5555, 1'b1, 4'b0000, 1};
    tbl[16] = '{1'b0, 1'b1, 3'd4, 16'hFFFF, 16'h0000, 16'h000F, 16'h8000, 1'b1, 4'b1010, 16};
    tbl[17] = '{1'b0, 1'b0, 3'd5, 16'h8000, 16'h001F, 16'h0000, 16'h0001, 1'b1, 4'b0000, 16};

    repeat (2) @(negedge clk);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst wr_en", 32'(out_wr_en), 32'd0);
    chk("rst result", 32'(result), 32'd0);
    chk("rst dest", 32'(out_dest), 32'd0);
    chk("rst flags", 32'(flags), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    #1 chk("rst in_ready", 32'(in_ready), 32'd1);

    issue32("w32 movt", 1'b0, 3'd1, 32'h0000ABCD, 32'h00001234, 32'h1234ABCD, 1'b1, 4'b0000);
    issue32("w32 set", 1'b0, 3'd3, 32'h0, 32'h0000000F, 32'h0, 1'b0, 4'b1111);
    issue32("w32 clr", 1'b0, 3'd2, 32'h0, 32'h00000004, 32'h0, 1'b0, 4'b1011);

    for (int i = 0; i < 18; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].ac, tbl[i].ui, tbl[i].op, 3'(i), tbl[i].a, tbl[i].b,
             tbl[i].im, tbl[i].res, tbl[i].wr, tbl[i].fl, tbl[i].lat);
    end
    m_flags = tbl[17].fl;

    // Hold A under back-pressure while B waits, then drain A/accept B and issue C with no gap.
    ra = ref_op(1'b1, 1'b1, 3'd1, 16'h0100, 16'h0, 16'h0023, m_flags);
    rb = ref_op(1'b0, 1'b1, 3'd0, 16'h0, 16'h0, 16'h4567, ra.fl);
    rc = ref_op(1'b1, 1'b1, 3'd5, 16'h00FF, 16'h0, 16'h0F0F, rb.fl);
    @(negedge clk);
    drive(1'b1, 1'b1, 3'd1, 3'd1, 16'h0100, 16'h0, 16'h0023);
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 drive(1'b0, 1'b1, 3'd0, 3'd2, 16'h0, 16'h0, 16'h4567);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp hold valid", 32'(out_valid), 32'd1);
      chk("bp hold result", 32'(result), 32'(ra.res));
      chk("bp hold flags", 32'(flags), 32'(ra.fl));
      chk("bp hold dest", 32'(out_dest), 32'd1);
      chk("bp hold in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1 chk("bp release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 drive(1'b1, 1'b1, 3'd5, 3'd3, 16'h00FF, 16'h0, 16'h0F0F);
    @(negedge clk);
    chk("b2b B valid", 32'(out_valid), 32'd1);
    chk("b2b B result", 32'(result), 32'(rb.res));
    chk("b2b B flags", 32'(flags), 32'(rb.fl));
    chk("b2b B dest", 32'(out_dest), 32'd2);
    chk("b2b B in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b C valid", 32'(out_valid), 32'd1);
    chk("b2b C result", 32'(result), 32'(rc.res));
    chk("b2b C flags", 32'(flags), 32'(rc.fl));
    chk("b2b C dest", 32'(out_dest), 32'd3);
    m_flags = rc.fl;

    // Reset in the middle of LSR by 7 must abort with no late result.
    r = ref_op(1'b0, 1'b1, 3'd3, 16'h0, 16'h0, 16'h000F, m_flags);
    run_op("pre-rst set", 1'b0, 1'b1, 3'd3, 3'd5, 16'h0, 16'h0, 16'h000F, r.res, r.wr, r.fl, r.lat);
    @(negedge clk);
    drive(1'b0, 1'b1, 3'd5, 3'd4, 16'hFF00, 16'h0, 16'h0007);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid-shift busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort flags", 32'(flags), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort wr_en", 32'(out_wr_en), 32'd0);
    chk("abort result", 32'(result), 32'd0);
    chk("abort dest", 32'(out_dest), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post-rst in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    chk("no late result", 32'(seen), 32'd0);
    m_flags = 4'h0;

    for (int i = 0; i < 150; i++) begin
      logic ac, ui;
      logic [2:0] o, dst;
      logic [15:0] a, b, im;
      ac = 1'($urandom_range(0, 1));
      ui = 1'($urandom_range(0, 1));
      o = 3'($urandom_range(0, 7));
      dst = 3'($urandom_range(0, 7));
      a = 16'($urandom);
      b = 16'($urandom);
      im = 16'($urandom);
      r = ref_op(ac, ui, o, a, b, im, m_flags);
      run_op($sformatf("rand%0d", i), ac, ui, o, dst, a, b, im, r.res, r.wr, r.fl, r.lat);
      m_flags = r.fl;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_unit.md
EX_UNIT -- requirements
Module: ex_unit

Interface
REQ-001 Parameter DATA_W, default 16, datapath width; SHALL be even and at least 8.
REQ-002 Parameter REG_AW, default 3, destination-register index width.
REQ-003 Parameter SH_W = $clog2(DATA_W), derived, shift-amount width.
REQ-004 Clocking SHALL be one clock; reset is asynchronous and active-low; ports clk and rst_n.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  issue request from decode.
REQ-008 in_ready  out  1  unit can accept an issue.
REQ-009 alu_class  in  1  1 = ALU op, 0 = move/shift/flag op.
REQ-010 use_imm  in  1  1 = operand B is imm, 0 = op2.
REQ-011 op  in  3  opcode within class.
REQ-012 dest_reg  in  REG_AW  destination index.
REQ-013 op1, op2, imm  in  DATA_W each  operands.
REQ-014 out_valid  out  1  result held.
REQ-015 out_ready  in  1  consumer accepts result.
REQ-016 result  out  DATA_W  registered result.
REQ-017 out_dest  out  REG_AW  registered destination.
REQ-018 out_wr_en  out  1  result is to be written to the register file.
REQ-019 flags  out  4  architectural {N,Z,C,V}.
REQ-020 busy  out  1  shift in progress.

Function
REQ-021 Handshake SHALL fire when in_valid && in_ready, with in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-022 Operand B SHALL be imm when use_imm=1, else op2.
REQ-023 alu_class=1 ops: 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 NOT(op1); any other opcode is NOP.
REQ-024 alu_class=0 ops: 000 MOV (B), 001 MOVT ({imm[DATA_W/2-1:0], op1[DATA_W/2-1:0]}), 100 LSL op1 by B[SH_W-1:0], 101 LSR op1 by B[SH_W-1:0], 010 CLR flags, 011 SET flags; any other opcode is NOP.
REQ-025 Non-shift ops, and shifts by 0, SHALL register their result one cycle after the handshake (latency 1).
REQ-026 A shift by s>0 SHALL enter state SHIFT, move 1 bit per cycle for s cycles, then register the result; latency is s+1 and busy=1 while in SHIFT.
REQ-027 State machine: IDLE -> SHIFT on a handshake with a shift op and s>0; SHIFT -> IDLE when the count reaches 0, loading the output register; all other accepted ops stay in IDLE.
REQ-028 ADD/SUB SHALL be computed at DATA_W+1 bits: C = carry-out for ADD, C = NOT borrow for SUB, V = signed overflow.
REQ-029 Logic ops, MOV and MOVT SHALL update N and Z only.
REQ-030 Shifts SHALL update N and Z; C = last bit shifted out; C is unchanged when s=0.
REQ-031 CLR/SET SHALL clear/set the flag bits selected by imm[3:0] (bit 3 = N ... bit 0 = V), with out_wr_en=0.
REQ-032 NOP SHALL produce out_valid with out_wr_en=0, result=0 and flags unchanged.
REQ-033 Flags SHALL update on the same edge that sets out_valid.
REQ-034 A held result SHALL stay stable until out_ready; a simultaneous drain and new issue in IDLE SHALL be accepted without a bubble.
REQ-035 Wrap-around: ADD/SUB results SHALL be taken modulo 2^DATA_W.

Reset
REQ-036 On rst_n=0: state=IDLE, out_valid=0, out_wr_en=0, result=0, out_dest=0, flags=0, busy=0, shift count=0, including when reset is asserted mid-shift, which aborts the shift with no output.
REQ-037 in_ready SHALL be 1 during the first cycle after reset release.

Structure
REQ-038 Package ex_pkg SHALL hold the opcode localparams, the flag bit indices and the state enum.
REQ-039 Sub-module ex_shifter SHALL implement the iterative shift and count, exposing start/done/C-out.

Verification
REQ-040 DATA_W=16: ADD op1=0x7FFF, imm=1 -> result 0x8000, flags N=1 Z=0 C=0 V=1, out_valid 1 cycle after handshake.
REQ-041 SUB op1=5, op2=5 -> result 0, Z=1, C=1, V=0.
REQ-042 LSL op1=0x8001, imm=3 -> busy for 3 cycles, result 0x0008, C=0, latency 4; in_ready=0 throughout.
REQ-043 out_ready held 0 for 5 cycles after a result -> result stable, in_ready=0; on release, back-to-back issues complete with no bubble.
REQ-044 rst_n pulsed low during LSR by 7 -> out_valid=0, flags=0, busy=0 immediately, and no result appears afterwards.
REQ-045 DATA_W=32: MOVT op1=0x0000ABCD, imm=0x1234 -> result 0x1234ABCD; SET imm=0xF then CLR imm=0x4 -> flags 4'b1011.
